// File: rtl/score_pkg.sv
// Shared types and glyph helpers for the multi-digit score renderer.
package score_pkg;

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    WON  = 1'b1
  } state_t;

  // Segment bit order is {g,f,e,d,c,b,a}; codes 10..15 light nothing.
  function automatic logic [6:0] seg_mask(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_mask = 7'h3F;
      4'd1:    seg_mask = 7'h06;
      4'd2:    seg_mask = 7'h5B;
      4'd3:    seg_mask = 7'h4F;
      4'd4:    seg_mask = 7'h66;
      4'd5:    seg_mask = 7'h6D;
      4'd6:    seg_mask = 7'h7D;
      4'd7:    seg_mask = 7'h07;
      4'd8:    seg_mask = 7'h7F;
      4'd9:    seg_mask = 7'h6F;
      default: seg_mask = 7'h00;
    endcase
  endfunction

  function automatic int cell_w(input int seg_w, input int seg_h);
    return 2 * seg_w + seg_h;
  endfunction

  function automatic int cell_h(input int seg_w, input int seg_h);
    return 3 * seg_w + 2 * seg_h;
  endfunction

  function automatic logic [15:0] to_bcd(input int value);
    int v;
    v = value;
    to_bcd = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      to_bcd[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

endpackage

// File: rtl/seg7_hit.sv
// Combinational test of whether a pixel lies on a lit segment of one digit cell.
module seg7_hit #(
  parameter int SEG_W = 10,
  parameter int SEG_H = 40
) (
  input  logic [3:0]  digit,
  input  logic [11:0] org_x,
  input  logic [11:0] org_y,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        lit
);
  import score_pkg::*;

  localparam logic [11:0] CW    = 12'(cell_w(SEG_W, SEG_H));
  localparam logic [11:0] CH    = 12'(cell_h(SEG_W, SEG_H));
  localparam logic [11:0] SW    = 12'(SEG_W);
  localparam logic [11:0] SWH   = 12'(SEG_W + SEG_H);
  localparam logic [11:0] S2WH  = 12'(2 * SEG_W + SEG_H);
  localparam logic [11:0] S2W2H = 12'(2 * SEG_W + 2 * SEG_H);

  logic [11:0] hc_s, vc_s, rx_s, ry_s;
  logic        in_cell_s;
  logic [6:0]  seg_s;

  assign hc_s = {1'b0, hcount};
  assign vc_s = {2'b00, vcount};
  assign rx_s = hc_s - org_x;
  assign ry_s = vc_s - org_y;

  // 12-bit sums keep the right/bottom cell edges from wrapping.
  assign in_cell_s = (hc_s >= org_x) && (hc_s < org_x + CW) &&
                     (vc_s >= org_y) && (vc_s < org_y + CH);

  assign seg_s[0] = (ry_s < SW);
  assign seg_s[1] = (rx_s >= SWH) && (ry_s < S2WH);
  assign seg_s[2] = (rx_s >= SWH) && (ry_s >= SWH);
  assign seg_s[3] = (ry_s >= S2W2H);
  assign seg_s[4] = (rx_s < SW) && (ry_s >= SWH);
  assign seg_s[5] = (rx_s < SW) && (ry_s < S2WH);
  assign seg_s[6] = (ry_s >= SWH) && (ry_s < S2WH);

  assign lit = in_cell_s & (|(seg_s & seg_mask(digit)));

endmodule

// File: rtl/score_display.sv
// BCD score keeper with win detection, blinking win display and seven-segment
// rendering into the pixel stream.
module score_display #(
  parameter int         DIGITS       = 2,
  parameter int         WIN_SCORE    = 10,
  parameter int         SEG_W        = 10,
  parameter int         SEG_H        = 40,
  parameter int         GAP          = 10,
  parameter int         Y_POS        = 50,
  parameter logic [7:0] COLOR        = 8'hCF,
  parameter bit         LZ_BLANK     = 1'b1,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  point,
  input  logic                  clear,
  input  logic                  frame_tick,
  input  logic [10:0]           hcount,
  input  logic [9:0]            vcount,
  input  logic [9:0]            x,
  output logic [7:0]            pixel,
  output logic                  over,
  output logic [4*DIGITS-1:0]   score_bcd
);
  import score_pkg::*;

  localparam int          SW       = 4 * DIGITS;
  localparam int          PITCH    = cell_w(SEG_W, SEG_H) + GAP;
  localparam int          BW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [15:0] WIN_BCD16 = to_bcd(WIN_SCORE);
  localparam logic [SW-1:0] WIN_BCD = WIN_BCD16[SW-1:0];
  localparam logic [BW-1:0] LAST_CNT = BW'(BLINK_FRAMES - 1);

  state_t          state_r, state_nxt_s;
  logic [SW-1:0]   score_r, score_nxt_s, score_inc_s;
  logic            over_r, over_nxt_s;
  logic [BW-1:0]   cnt_r, cnt_nxt_s;
  logic            blank_r, blank_nxt_s;
  logic [7:0]      pixel_r;
  logic [3:0]      glyph_s [DIGITS];
  logic [DIGITS-1:0] hit_s;

  // BCD ripple increment of the current score.
  always_comb begin
    logic carry;
    carry       = 1'b1;
    score_inc_s = score_r;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (score_r[4*k +: 4] == 4'd9) begin
          score_inc_s[4*k +: 4] = 4'd0;
        end else begin
          score_inc_s[4*k +: 4] = score_r[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end else begin
        score_inc_s[4*k +: 4] = score_r[4*k +: 4];
      end
    end
  end

  // Next-state logic for match state, score, win flag and blink phase.
  always_comb begin
    state_nxt_s = state_r;
    score_nxt_s = score_r;
    over_nxt_s  = over_r;
    cnt_nxt_s   = cnt_r;
    blank_nxt_s = blank_r;
    if (clear) begin
      state_nxt_s = PLAY;
      score_nxt_s = '0;
      over_nxt_s  = 1'b0;
      cnt_nxt_s   = '0;
      blank_nxt_s = 1'b0;
    end else begin
      case (state_r)
        PLAY: begin
          cnt_nxt_s   = '0;
          blank_nxt_s = 1'b0;
          if (point) begin
            score_nxt_s = score_inc_s;
            if (score_inc_s == WIN_BCD) begin
              over_nxt_s  = 1'b1;
              state_nxt_s = WON;
            end else begin
              over_nxt_s  = 1'b0;
            end
          end else begin
            score_nxt_s = score_r;
          end
        end
        WON: begin
          if (frame_tick) begin
            if (cnt_r == LAST_CNT) begin
              cnt_nxt_s   = '0;
              blank_nxt_s = ~blank_r;
            end else begin
              cnt_nxt_s   = cnt_r + BW'(1);
            end
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        default: begin
          state_nxt_s = PLAY;
          over_nxt_s  = 1'b0;
          cnt_nxt_s   = '0;
          blank_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Digit selection, most significant first; blanked leading zeros map to an unlit code.
  always_comb begin
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      seen = seen | (score_r[4*(DIGITS-1-k) +: 4] != 4'd0);
      if (!LZ_BLANK || seen || (k == DIGITS - 1)) begin
        glyph_s[k] = score_r[4*(DIGITS-1-k) +: 4];
      end else begin
        glyph_s[k] = 4'hF;
      end
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    seg7_hit #(.SEG_W(SEG_W), .SEG_H(SEG_H)) u_hit (
      .digit  (glyph_s[k]),
      .org_x  ({2'b00, x} + 12'(k * PITCH)),
      .org_y  (12'(Y_POS)),
      .hcount (hcount),
      .vcount (vcount),
      .lit    (hit_s[k])
    );
  end

  // State, score and registered pixel output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= PLAY;
      score_r <= '0;
      over_r  <= 1'b0;
      cnt_r   <= '0;
      blank_r <= 1'b0;
      pixel_r <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      score_r <= score_nxt_s;
      over_r  <= over_nxt_s;
      cnt_r   <= cnt_nxt_s;
      blank_r <= blank_nxt_s;
      pixel_r <= ((|hit_s) && !blank_r) ? COLOR : 8'h00;
    end
  end

  assign pixel     = pixel_r;
  assign over      = over_r;
  assign score_bcd = score_r;

endmodule
